ddr5_ca_cmd_gen: RTL and testbench

//  Controller-side DDR5 command issuer: drives cs_n/ca[13:0] into ddr5_dram.

---
 rtl/ddr5_ca_cmd_gen_if.sv | 28 ++
 rtl/ddr5_ca_cmd_gen.sv | 205 ++++++++++++++++++++
 tb/tb_ddr5_ca_cmd_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_ca_cmd_gen_if.sv
// Request channel into the DDR5 CA command generator: valid/ready handshake
// carrying the access direction plus target row and column.
interface ddr5_ca_cmd_gen_if #(
    parameter int ROW_W = 16,
    parameter int COL_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;

    modport master (
        output req_valid,
        output req_write,
        output req_row,
        output req_col,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_row,
        input  req_col,
        output req_ready
    );
endinterface

// File: rtl/ddr5_ca_cmd_gen.sv
// Controller-side DDR5 command issuer: tracks one open row, sequences PREab/ACT
// ahead of a two-cycle RD/WR on cs_n/ca, and enforces tRP, tRCD and tCCD.
//
// state    | meaning
// IDLE     | waiting for a request (ready once tCCD allows a CAS next cycle)
// PRE      | PREab driven, closes the open row
// WAIT_RP  | counting down tRP before ACT
// ACT1     | ACT cycle 1 (row[11:0])
// ACT2     | ACT cycle 2 (row[15:12]); row now open
// WAIT_RCD | counting down tRCD before CAS
// CAS1     | RD/WR cycle 1 (opcode)
// CAS2     | RD/WR cycle 2 (column); cmd_done pulses
module ddr5_ca_cmd_gen #(
    parameter int ROW_W = 16,
    parameter int COL_W = 10,
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_CCD = 4
) (
    input  logic              ck_t,
    input  logic              rst,
    ddr5_ca_cmd_gen_if.slave  bus,
    output logic              cs_n,
    output logic [13:0]       ca,
    output logic              cmd_done,
    output logic              row_open
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_RP,
        ACT1,
        ACT2,
        WAIT_RCD,
        CAS1,
        CAS2
    } state_t;

    // Wait states are entered one cycle after PRE / two after ACT1, so the
    // preload leaves exactly T_RP / T_RCD cycles between command starts.
    localparam logic [7:0] RP_LOAD  = (T_RP  >= 2) ? 8'(T_RP - 2)  : 8'd0;
    localparam logic [7:0] RCD_LOAD = (T_RCD >= 3) ? 8'(T_RCD - 3) : 8'd0;
    localparam logic [3:0] CCD_LOAD = 4'(T_CCD - 1);

    localparam logic [13:0] CA_PREAB = 14'h000B;
    localparam logic [13:0] CA_RD    = 14'h001D;
    localparam logic [13:0] CA_WR    = 14'h000D;

    state_t           state, state_nxt;
    logic [7:0]       tmr, tmr_nxt;
    logic [3:0]       ccd, ccd_nxt;
    logic             req_ready_q;

    logic             lat_write;
    logic [ROW_W-1:0] lat_row;
    logic [COL_W-1:0] lat_col;
    logic [ROW_W-1:0] open_row;

    logic             accept;
    logic             hit;
    logic             cmd_write;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic [15:0]      row_ext;
    logic             cs_n_nxt;
    logic [13:0]      ca_nxt;

    assign bus.req_ready = req_ready_q;

    always_comb begin
        accept = (state == IDLE) && bus.req_valid && req_ready_q;
        hit    = row_open && (bus.req_row == open_row);
    end

    // The command driven next cycle may belong to the request being accepted
    // right now, before its fields reach the latches.
    always_comb begin
        cmd_write = accept ? bus.req_write : lat_write;
        cmd_row   = accept ? bus.req_row   : lat_row;
        cmd_col   = accept ? bus.req_col   : lat_col;
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        state_nxt = CAS1;
                    end else if (row_open) begin
                        state_nxt = PRE;
                    end else begin
                        state_nxt = ACT1;
                    end
                end
            end
            PRE: begin
                if (T_RP <= 1) begin
                    state_nxt = ACT1;
                end else begin
                    state_nxt = WAIT_RP;
                    tmr_nxt   = RP_LOAD;
                end
            end
            WAIT_RP: begin
                if (tmr == 8'd0) begin
                    state_nxt = ACT1;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            ACT1: state_nxt = ACT2;
            ACT2: begin
                if (T_RCD <= 2) begin
                    state_nxt = CAS1;
                end else begin
                    state_nxt = WAIT_RCD;
                    tmr_nxt   = RCD_LOAD;
                end
            end
            WAIT_RCD: begin
                if (tmr == 8'd0) begin
                    state_nxt = CAS1;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            CAS1:    state_nxt = CAS2;
            CAS2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tCCD keeps running across PRE/ACT; it only reloads on a new CAS.
    always_comb begin
        ccd_nxt = ccd;
        if (state_nxt == CAS1) begin
            ccd_nxt = CCD_LOAD;
        end else if (ccd != 4'd0) begin
            ccd_nxt = ccd - 4'd1;
        end
    end

    always_comb begin
        cs_n_nxt = 1'b1;
        ca_nxt   = 14'd0;
        row_ext  = 16'(cmd_row);
        case (state_nxt)
            PRE: begin
                cs_n_nxt = 1'b0;
                ca_nxt   = CA_PREAB;
            end
            ACT1: begin
                cs_n_nxt = 1'b0;
                ca_nxt   = {row_ext[11:0], 2'b00};
            end
            ACT2: ca_nxt = {10'd0, row_ext[15:12]};
            CAS1: begin
                cs_n_nxt = 1'b0;
                ca_nxt   = cmd_write ? CA_WR : CA_RD;
            end
            CAS2:    ca_nxt = 14'(cmd_col);
            default: ca_nxt = 14'd0;
        endcase
    end

    always_ff @(posedge ck_t) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= 8'd0;
            ccd         <= 4'd0;
            req_ready_q <= 1'b0;
            cs_n        <= 1'b1;
            ca          <= 14'd0;
            cmd_done    <= 1'b0;
            row_open    <= 1'b0;
            open_row    <= '0;
            lat_write   <= 1'b0;
            lat_row     <= '0;
            lat_col     <= '0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            ccd         <= ccd_nxt;
            req_ready_q <= (state_nxt == IDLE) && (ccd_nxt == 4'd0);
            cs_n        <= cs_n_nxt;
            ca          <= ca_nxt;
            cmd_done    <= (state_nxt == CAS2);
            if (state_nxt == PRE) begin
                row_open <= 1'b0;
            end else if (state_nxt == ACT2) begin
                row_open <= 1'b1;
                open_row <= lat_row;
            end
            if (accept) begin
                lat_write <= bus.req_write;
                lat_row   <= bus.req_row;
                lat_col   <= bus.req_col;
            end
        end
    end

endmodule

// File: tb/tb_ddr5_ca_cmd_gen.sv
// Directed bench for ddr5_ca_cmd_gen: reset, closed/hit/miss sequencing,
// tCCD spacing under back-to-back hits, and reset in the middle of a command.
module tb_ddr5_ca_cmd_gen;

    logic        ck_t = 1'b0;
    logic        rst  = 1'b1;
    logic        cs_n;
    logic [13:0] ca;
    logic        cmd_done;
    logic        row_open;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    always #5 ck_t = ~ck_t;

    ddr5_ca_cmd_gen_if #(.ROW_W(16), .COL_W(10)) bus ();

    ddr5_ca_cmd_gen #(
        .ROW_W(16), .COL_W(10), .T_RCD(4), .T_RP(4), .T_CCD(4)
    ) dut (
        .ck_t     (ck_t),
        .rst      (rst),
        .bus      (bus.slave),
        .cs_n     (cs_n),
        .ca       (ca),
        .cmd_done (cmd_done),
        .row_open (row_open)
    );

    task automatic tick();
        @(posedge ck_t);
        #1;
        cyc++;
    endtask

    // Presents one request and returns in cycle a+1 (a = accept cycle).
    task automatic send(input logic w, input logic [15:0] row, input logic [9:0] col);
        bit ok = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_row   = row;
        bus.req_col   = col;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.req_ready === 1'b1) ok = 1;
            tick();
        end
        bus.req_valid = 1'b0;
        chk_cnt++;
        if (!ok) $display("FAIL send_handshake: req_ready never seen within 64 cycles, want accept");
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        chk_cnt++;
        if ({cs_n, ca, bus.req_ready, row_open, cmd_done} !== {1'b1, 14'h0000, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_values: got cs_n=%b ca=%h rdy=%b open=%b done=%b want 1/0000/0/0/0",
                     cs_n, ca, bus.req_ready, row_open, cmd_done);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_closed_read();
        send(1'b0, 16'h1234, 10'h05A);
        chk_cnt++;
        if ({cs_n, ca} !== {1'b0, 14'h08D0}) $display("FAIL closed_act1: got cs_n=%b ca=%h want 0/08d0", cs_n, ca);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({cs_n, ca, row_open} !== {1'b1, 14'h0001, 1'b1})
            $display("FAIL closed_act2: got cs_n=%b ca=%h open=%b want 1/0001/1", cs_n, ca, row_open);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++;
            if ({cs_n, ca} !== {1'b1, 14'h0000}) $display("FAIL closed_trcd_nop%0d: got cs_n=%b ca=%h want 1/0000", k, cs_n, ca);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({cs_n, ca, cmd_done} !== {1'b0, 14'h001D, 1'b0})
            $display("FAIL closed_cas1: got cs_n=%b ca=%h done=%b want 0/001d/0", cs_n, ca, cmd_done);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({cs_n, ca, cmd_done} !== {1'b1, 14'h005A, 1'b1})
            $display("FAIL closed_cas2: got cs_n=%b ca=%h done=%b want 1/005a/1", cs_n, ca, cmd_done);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (cmd_done !== 1'b0) $display("FAIL closed_done_pulse: got %b want 0", cmd_done);
        else pass_cnt++;
    endtask

    task automatic test_hit_write();
        send(1'b1, 16'h1234, 10'h3FF);
        chk_cnt++;
        if ({cs_n, ca} !== {1'b0, 14'h000D}) $display("FAIL hit_cas1: got cs_n=%b ca=%h want 0/000d", cs_n, ca);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({cs_n, ca, cmd_done} !== {1'b1, 14'h03FF, 1'b1})
            $display("FAIL hit_cas2: got cs_n=%b ca=%h done=%b want 1/03ff/1", cs_n, ca, cmd_done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_miss_read();
        send(1'b0, 16'h0001, 10'h022);
        chk_cnt++;
        if ({cs_n, ca, row_open} !== {1'b0, 14'h000B, 1'b0})
            $display("FAIL miss_pre: got cs_n=%b ca=%h open=%b want 0/000b/0", cs_n, ca, row_open);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++;
            if (cs_n !== 1'b1) $display("FAIL miss_trp_nop%0d: got cs_n=%b want 1", k, cs_n);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({cs_n, ca} !== {1'b0, 14'h0004}) $display("FAIL miss_act1: got cs_n=%b ca=%h want 0/0004", cs_n, ca);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({cs_n, ca, row_open} !== {1'b1, 14'h0000, 1'b1})
            $display("FAIL miss_act2: got cs_n=%b ca=%h open=%b want 1/0000/1", cs_n, ca, row_open);
        else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++;
        if ({cs_n, ca} !== {1'b0, 14'h001D}) $display("FAIL miss_cas1: got cs_n=%b ca=%h want 0/001d", cs_n, ca);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({ca, cmd_done, row_open} !== {14'h0022, 1'b1, 1'b1})
            $display("FAIL miss_cas2: got ca=%h done=%b open=%b want 0022/1/1", ca, cmd_done, row_open);
        else pass_cnt++;
    endtask

    // Row 0x0001 is left open by the miss test, so all three are hits.
    task automatic test_back_to_back();
        int          cas_cyc[3];
        logic [13:0] cas_ca[3];
        int          ncas = 0;
        int          nacc = 0;
        logic        acc;
        bus.req_write = 1'b0;
        bus.req_row   = 16'h0001;
        bus.req_col   = 10'h100;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 60 && ncas < 3; i++) begin
            if (cs_n === 1'b0) begin
                cas_cyc[ncas] = cyc;
                cas_ca[ncas]  = ca;
                ncas++;
            end
            acc = bus.req_valid && (bus.req_ready === 1'b1);
            tick();
            if (acc) begin
                nacc++;
                if (nacc == 3) bus.req_valid = 1'b0;
                else bus.req_col = 10'h100 + 10'(nacc);
            end
        end
        bus.req_valid = 1'b0;
        chk_cnt++;
        if (ncas != 3 || nacc != 3) $display("FAIL b2b_count: got cas=%0d acc=%0d want 3/3", ncas, nacc);
        else pass_cnt++;
        if (ncas == 3) begin
            chk_cnt++;
            if (cas_cyc[1] - cas_cyc[0] != 4) $display("FAIL b2b_gap01: got %0d want 4", cas_cyc[1] - cas_cyc[0]);
            else pass_cnt++;
            chk_cnt++;
            if (cas_cyc[2] - cas_cyc[1] != 4) $display("FAIL b2b_gap12: got %0d want 4", cas_cyc[2] - cas_cyc[1]);
            else pass_cnt++;
            chk_cnt++;
            if ({cas_ca[0], cas_ca[1], cas_ca[2]} !== {14'h001D, 14'h001D, 14'h001D})
                $display("FAIL b2b_opcodes: got %h %h %h want 001d x3", cas_ca[0], cas_ca[1], cas_ca[2]);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({ca, cmd_done} !== {14'h0102, 1'b1}) $display("FAIL b2b_last_col: got ca=%h done=%b want 0102/1", ca, cmd_done);
        else pass_cnt++;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_cmd();
        send(1'b0, 16'h0002, 10'h003);
        repeat (6) tick();
        chk_cnt++;
        if ({cs_n, row_open} !== {1'b1, 1'b1}) $display("FAIL rst_mid_pre: got cs_n=%b open=%b want 1/1", cs_n, row_open);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++;
        if ({cs_n, ca, bus.req_ready, row_open, cmd_done} !== {1'b1, 14'h0000, 1'b0, 1'b0, 1'b0})
            $display("FAIL rst_mid_values: got cs_n=%b ca=%h rdy=%b open=%b done=%b want 1/0000/0/0/0",
                     cs_n, ca, bus.req_ready, row_open, cmd_done);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        send(1'b0, 16'h0002, 10'h003);
        chk_cnt++;
        if ({cs_n, ca} !== {1'b0, 14'h0008}) $display("FAIL rst_mid_act: got cs_n=%b ca=%h want 0/0008", cs_n, ca);
        else pass_cnt++;
        repeat (4) tick();
        chk_cnt++;
        if ({cs_n, ca} !== {1'b0, 14'h001D}) $display("FAIL rst_mid_cas1: got cs_n=%b ca=%h want 0/001d", cs_n, ca);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({ca, cmd_done} !== {14'h0003, 1'b1}) $display("FAIL rst_mid_cas2: got ca=%h done=%b want 0003/1", ca, cmd_done);
        else pass_cnt++;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_row   = 16'h0000;
        bus.req_col   = 10'h000;
        test_reset();
        test_closed_read();
        test_hit_write();
        test_miss_read();
        test_back_to_back();
        test_reset_mid_cmd();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
